// File: rtl/fitness_eval_ctrl_if.sv
//==============================================================================
// Module      : fitness_eval_ctrl_if
// Description : Handshake/bus bundle between the fitness evaluation controller
//               and its coefficient ROM, evaluator, population and fitness
//               memories. master = controller side, slave = environment side.
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

interface fitness_eval_ctrl_if #(
    parameter int DATA_WIDTH        = 4,
    parameter int INDIVIDUAL_LENGTH = 22,
    parameter int SELF_FIT_LENGTH   = 10,
    parameter int IDX_WIDTH         = 8
);
    logic                         start_i;
    logic                         reload_i;
    logic [3:0]                   cfg_addr_o;
    logic [DATA_WIDTH-1:0]        cfg_data_i;
    logic [DATA_WIDTH-1:0]        self_energy_o;
    logic [DATA_WIDTH-1:0]        interact_energy_o;
    logic                         wr_self_valid_o;
    logic                         wr_interact_valid_o;
    logic                         pop_rd_en_o;
    logic [IDX_WIDTH-1:0]         pop_addr_o;
    logic [INDIVIDUAL_LENGTH-1:0] pop_data_i;
    logic                         eval_valid_o;
    logic [INDIVIDUAL_LENGTH-1:0] eval_ind_o;
    logic [IDX_WIDTH-1:0]         eval_idx_o;
    logic                         eval_valid_i;
    logic [SELF_FIT_LENGTH-1:0]   eval_energy_i;
    logic [IDX_WIDTH-1:0]         eval_idx_i;
    logic                         fit_wr_en_o;
    logic [IDX_WIDTH-1:0]         fit_addr_o;
    logic [SELF_FIT_LENGTH-1:0]   fit_data_o;
    logic [SELF_FIT_LENGTH-1:0]   best_energy_o;
    logic [IDX_WIDTH-1:0]         best_idx_o;
    logic                         busy_o;
    logic                         done_o;

    modport master (
        input  start_i, reload_i, cfg_data_i, pop_data_i,
               eval_valid_i, eval_energy_i, eval_idx_i,
        output cfg_addr_o, self_energy_o, interact_energy_o,
               wr_self_valid_o, wr_interact_valid_o,
               pop_rd_en_o, pop_addr_o,
               eval_valid_o, eval_ind_o, eval_idx_o,
               fit_wr_en_o, fit_addr_o, fit_data_o,
               best_energy_o, best_idx_o, busy_o, done_o
    );

    modport slave (
        output start_i, reload_i, cfg_data_i, pop_data_i,
               eval_valid_i, eval_energy_i, eval_idx_i,
        input  cfg_addr_o, self_energy_o, interact_energy_o,
               wr_self_valid_o, wr_interact_valid_o,
               pop_rd_en_o, pop_addr_o,
               eval_valid_o, eval_ind_o, eval_idx_o,
               fit_wr_en_o, fit_addr_o, fit_data_o,
               best_energy_o, best_idx_o, busy_o, done_o
    );
endinterface

`default_nettype wire

// File: rtl/fitness_eval_ctrl.sv
//==============================================================================
// Module      : fitness_eval_ctrl
// Description : Sequences one generation of fitness evaluation: optional
//               reload of self/interaction energy coefficients from ROM,
//               streaming of the population into the evaluator, write-back
//               of results to fitness memory and completion detection.
//               Optional macro FEC_BEST_TRACK_EN builds minimum-energy
//               tracking; without it best_energy_o/best_idx_o are tied to 0.
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module fitness_eval_ctrl #(
    parameter int NUM_PARTICLE_TYPE = 3,
    parameter int DATA_WIDTH        = 4,
    parameter int INDIVIDUAL_LENGTH = 22,
    parameter int SELF_FIT_LENGTH   = 10,
    parameter int POP_SIZE          = 50,
    parameter int IDX_WIDTH         = 8
) (
    input  wire logic            clk_i,
    input  wire logic            rst_n,
    fitness_eval_ctrl_if.master  bus
);

    localparam logic [2:0] c_IDLE    = 3'd0;
    localparam logic [2:0] c_LOAD_SE = 3'd1;
    localparam logic [2:0] c_LOAD_IE = 3'd2;
    localparam logic [2:0] c_ISSUE   = 3'd3;
    localparam logic [2:0] c_DRAIN   = 3'd4;
    localparam logic [2:0] c_DONE    = 3'd5;

    // ROM layout: self energies first, then the interaction matrix row-major
    localparam logic [3:0] c_SE_LAST = 4'(NUM_PARTICLE_TYPE - 1);
    localparam logic [3:0] c_IE_LAST = 4'(NUM_PARTICLE_TYPE + NUM_PARTICLE_TYPE * NUM_PARTICLE_TYPE - 1);
    localparam logic [IDX_WIDTH-1:0] c_POP_LAST = IDX_WIDTH'(POP_SIZE - 1);
    localparam logic [IDX_WIDTH-1:0] c_POP_SIZE = IDX_WIDTH'(POP_SIZE);

    logic [2:0]                   r_state;
    logic [2:0]                   w_state_nxt;
    logic [3:0]                   r_cfg_cnt;
    logic [IDX_WIDTH-1:0]         r_issue_cnt;
    logic [IDX_WIDTH-1:0]         r_rx_cnt;
    logic [IDX_WIDTH-1:0]         w_rx_cnt_nxt;
    logic                         r_loaded;
    logic                         r_se_wr;
    logic                         r_ie_wr;
    logic                         r_eval_valid;
    logic [IDX_WIDTH-1:0]         r_eval_idx;
    logic                         w_loading;
    logic                         w_issuing;
    logic                         w_count;
    logic                         w_start_acc;
    logic [DATA_WIDTH-1:0]        w_cfg_data;
    logic [INDIVIDUAL_LENGTH-1:0] w_eval_ind;
    logic [SELF_FIT_LENGTH-1:0]   w_fit_data;

    assign w_loading   = (r_state == c_LOAD_SE) || (r_state == c_LOAD_IE);
    assign w_issuing   = (r_state == c_ISSUE);
    assign w_start_acc = (r_state == c_IDLE) && bus.start_i;
    // Results are counted only while a generation is in flight; idle writes
    // still reach fitness memory but do not contribute to completion.
    assign w_count      = bus.eval_valid_i && (w_loading || w_issuing || (r_state == c_DRAIN));
    assign w_rx_cnt_nxt = r_rx_cnt + {{(IDX_WIDTH-1){1'b0}}, w_count};

    // Next-state decode; DRAIN looks at the post-increment count so a result
    // arriving in the current cycle closes the generation immediately.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE: begin
                if (bus.start_i) begin
                    w_state_nxt = (bus.reload_i || !r_loaded) ? c_LOAD_SE : c_ISSUE;
                end
            end
            c_LOAD_SE: if (r_cfg_cnt == c_SE_LAST)     w_state_nxt = c_LOAD_IE;
            c_LOAD_IE: if (r_cfg_cnt == c_IE_LAST)     w_state_nxt = c_ISSUE;
            c_ISSUE:   if (r_issue_cnt == c_POP_LAST)  w_state_nxt = c_DRAIN;
            c_DRAIN:   if (w_rx_cnt_nxt >= c_POP_SIZE) w_state_nxt = c_DONE;
            c_DONE:    w_state_nxt = c_IDLE;
            default:   w_state_nxt = c_IDLE;
        endcase
    end

    // State, counters, loaded flag and the one-cycle-delayed strobes
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= c_IDLE;
            r_cfg_cnt    <= 4'd0;
            r_issue_cnt  <= '0;
            r_rx_cnt     <= '0;
            r_loaded     <= 1'b0;
            r_se_wr      <= 1'b0;
            r_ie_wr      <= 1'b0;
            r_eval_valid <= 1'b0;
            r_eval_idx   <= '0;
        end else begin
            r_state <= w_state_nxt;

            if (w_loading) begin
                r_cfg_cnt <= (r_cfg_cnt == c_IE_LAST) ? 4'd0 : r_cfg_cnt + 4'd1;
            end else begin
                r_cfg_cnt <= 4'd0;
            end

            if ((r_state == c_LOAD_IE) && (r_cfg_cnt == c_IE_LAST)) begin
                r_loaded <= 1'b1;
            end

            if (r_state == c_DONE) begin
                r_issue_cnt <= '0;
            end else if (w_issuing && (r_issue_cnt != c_POP_LAST)) begin
                r_issue_cnt <= r_issue_cnt + 1'b1;
            end

            if (r_state == c_DONE) begin
                r_rx_cnt <= '0;
            end else begin
                r_rx_cnt <= w_rx_cnt_nxt;
            end

            // ROM and population memory answer one cycle after the address
            r_se_wr      <= (r_state == c_LOAD_SE);
            r_ie_wr      <= (r_state == c_LOAD_IE);
            r_eval_valid <= w_issuing;
            r_eval_idx   <= w_issuing ? r_issue_cnt : '0;
        end
    end

    assign w_cfg_data = bus.cfg_data_i;
    assign w_eval_ind = r_eval_valid ? bus.pop_data_i : '0;
    assign w_fit_data = bus.eval_valid_i ? bus.eval_energy_i : '0;

    assign bus.cfg_addr_o          = w_loading ? r_cfg_cnt : 4'd0;
    assign bus.wr_self_valid_o     = r_se_wr;
    assign bus.self_energy_o       = r_se_wr ? w_cfg_data : '0;
    assign bus.wr_interact_valid_o = r_ie_wr;
    assign bus.interact_energy_o   = r_ie_wr ? w_cfg_data : '0;
    assign bus.pop_rd_en_o         = w_issuing;
    assign bus.pop_addr_o          = w_issuing ? r_issue_cnt : '0;
    assign bus.eval_valid_o        = r_eval_valid;
    assign bus.eval_ind_o          = w_eval_ind;
    assign bus.eval_idx_o          = r_eval_idx;
    assign bus.fit_wr_en_o         = bus.eval_valid_i;
    assign bus.fit_addr_o          = bus.eval_valid_i ? bus.eval_idx_i : '0;
    assign bus.fit_data_o          = w_fit_data;
    assign bus.busy_o              = (r_state != c_IDLE);
    assign bus.done_o              = (r_state == c_DONE);

`ifdef FEC_BEST_TRACK_EN
    logic [SELF_FIT_LENGTH-1:0] r_best_energy;
    logic [IDX_WIDTH-1:0]       r_best_idx;

    // Minimum-energy tracker; strict compare keeps the earliest of equal results
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            r_best_energy <= '1;
            r_best_idx    <= '0;
        end else if (w_start_acc) begin
            r_best_energy <= '1;
            r_best_idx    <= '0;
        end else if (w_count && (bus.eval_energy_i < r_best_energy)) begin
            r_best_energy <= bus.eval_energy_i;
            r_best_idx    <= bus.eval_idx_i;
        end
    end

    assign bus.best_energy_o = r_best_energy;
    assign bus.best_idx_o    = r_best_idx;
`else
    logic w_unused_start;
    assign w_unused_start    = w_start_acc;
    assign bus.best_energy_o = '0;
    assign bus.best_idx_o    = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fitness_eval_ctrl.sv
//==============================================================================
// Module      : tb_fitness_eval_ctrl
// Description : Self-checking bench for fitness_eval_ctrl with a ROM model
//               (address a holds a+1), a population memory model and an
//               evaluator model of configurable latency (energy = idx+100,
//               except idx 17 and 30 which return 5).
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_fitness_eval_ctrl;

    localparam int NUM_PARTICLE_TYPE = 3;
    localparam int DATA_WIDTH        = 4;
    localparam int INDIVIDUAL_LENGTH = 22;
    localparam int SELF_FIT_LENGTH   = 10;
    localparam int POP_SIZE          = 50;
    localparam int IDX_WIDTH         = 8;

`ifdef FEC_BEST_TRACK_EN
    localparam logic [SELF_FIT_LENGTH-1:0] EXP_BEST_E     = 10'd5;
    localparam logic [IDX_WIDTH-1:0]       EXP_BEST_I     = 8'd17;
    localparam logic [SELF_FIT_LENGTH-1:0] EXP_BEST_E_RST = 10'h3FF;
`else
    localparam logic [SELF_FIT_LENGTH-1:0] EXP_BEST_E     = 10'd0;
    localparam logic [IDX_WIDTH-1:0]       EXP_BEST_I     = 8'd0;
    localparam logic [SELF_FIT_LENGTH-1:0] EXP_BEST_E_RST = 10'd0;
`endif

    logic clk_i = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk_i = ~clk_i;

    fitness_eval_ctrl_if #(
        .DATA_WIDTH(DATA_WIDTH), .INDIVIDUAL_LENGTH(INDIVIDUAL_LENGTH),
        .SELF_FIT_LENGTH(SELF_FIT_LENGTH), .IDX_WIDTH(IDX_WIDTH)
    ) bus ();

    fitness_eval_ctrl #(
        .NUM_PARTICLE_TYPE(NUM_PARTICLE_TYPE), .DATA_WIDTH(DATA_WIDTH),
        .INDIVIDUAL_LENGTH(INDIVIDUAL_LENGTH), .SELF_FIT_LENGTH(SELF_FIT_LENGTH),
        .POP_SIZE(POP_SIZE), .IDX_WIDTH(IDX_WIDTH)
    ) dut (
        .clk_i (clk_i),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // scoreboards: expected values queued when stimulus is set up or driven
    int q_self[$];
    int q_int[$];
    int q_pop[$];
    int q_eval[$];
    int q_fit[$];

    int n_self, n_int, n_pop, n_ev, n_fit, n_done;
    int start_cyc, first_pop, last_pop, first_ev, done_cyc;
    int cur_lat = 4;
    bit hv[4];
    int hi[4];
    int prev_cfg = 0;
    bit prev_rd  = 1'b0;
    int prev_pa  = 0;

    function automatic logic [INDIVIDUAL_LENGTH-1:0] ind_of(input int a);
        return INDIVIDUAL_LENGTH'(a * 40503 + 12345);
    endfunction

    function automatic logic [SELF_FIT_LENGTH-1:0] energy_of(input int i);
        return (i == 17 || i == 30) ? 10'd5 : SELF_FIT_LENGTH'(i + 100);
    endfunction

    // One clock cycle: models answer at the falling edge, outputs checked just after
    task automatic step();
        bit v;
        int vi;
        int e;
        @(negedge clk_i);
        cyc++;
        bus.cfg_data_i = DATA_WIDTH'(prev_cfg + 1);
        bus.pop_data_i = prev_rd ? ind_of(prev_pa) : '0;
        if (cur_lat == 0) begin
            v  = bus.eval_valid_o;
            vi = int'(bus.eval_idx_o);
        end else begin
            v  = hv[cur_lat-1];
            vi = hi[cur_lat-1];
        end
        if (!rst_n) v = 1'b0;
        bus.eval_valid_i  = v;
        bus.eval_idx_i    = v ? IDX_WIDTH'(vi) : '0;
        bus.eval_energy_i = v ? energy_of(vi) : '0;
        if (v) q_fit.push_back(vi);
        #1;
        if (bus.wr_self_valid_o && bus.wr_interact_valid_o) begin
            checks++; errors++;
            $display("FAIL cfg_strobe_overlap cyc=%0d: both strobes high, required at most one", cyc);
        end
        if (bus.wr_self_valid_o) begin
            n_self++; checks++;
            if (q_self.size() == 0) begin
                errors++;
                $display("FAIL self_strobe cyc=%0d: got data %0d, required no strobe", cyc, bus.self_energy_o);
            end else begin
                e = q_self.pop_front();
                if (bus.self_energy_o !== DATA_WIDTH'(e)) begin
                    errors++;
                    $display("FAIL self_energy cyc=%0d: got %0d, required %0d", cyc, bus.self_energy_o, e);
                end
            end
        end
        if (bus.wr_interact_valid_o) begin
            n_int++; checks++;
            if (q_int.size() == 0) begin
                errors++;
                $display("FAIL interact_strobe cyc=%0d: got data %0d, required no strobe", cyc, bus.interact_energy_o);
            end else begin
                e = q_int.pop_front();
                if (bus.interact_energy_o !== DATA_WIDTH'(e)) begin
                    errors++;
                    $display("FAIL interact_energy cyc=%0d: got %0d, required %0d", cyc, bus.interact_energy_o, e);
                end
            end
        end
        if (bus.pop_rd_en_o) begin
            n_pop++; checks++;
            if (first_pop < 0) first_pop = cyc;
            last_pop = cyc;
            if (q_pop.size() == 0) begin
                errors++;
                $display("FAIL pop_read cyc=%0d: got addr %0d, required no read", cyc, bus.pop_addr_o);
            end else begin
                e = q_pop.pop_front();
                if (bus.pop_addr_o !== IDX_WIDTH'(e)) begin
                    errors++;
                    $display("FAIL pop_addr cyc=%0d: got %0d, required %0d", cyc, bus.pop_addr_o, e);
                end
            end
        end
        if (bus.eval_valid_o) begin
            n_ev++; checks++;
            if (first_ev < 0) first_ev = cyc;
            if (q_eval.size() == 0) begin
                errors++;
                $display("FAIL eval_issue cyc=%0d: got idx %0d, required no issue", cyc, bus.eval_idx_o);
            end else begin
                e = q_eval.pop_front();
                if (bus.eval_idx_o !== IDX_WIDTH'(e) || bus.eval_ind_o !== ind_of(e)) begin
                    errors++;
                    $display("FAIL eval_issue cyc=%0d: got idx %0d ind %h, required idx %0d ind %h",
                             cyc, bus.eval_idx_o, bus.eval_ind_o, e, ind_of(e));
                end
            end
        end
        if (bus.fit_wr_en_o || v) begin
            n_fit += bus.fit_wr_en_o ? 1 : 0;
            checks++;
            if (bus.fit_wr_en_o !== v || q_fit.size() == 0) begin
                errors++;
                $display("FAIL fit_wr_en cyc=%0d: got %0b, required %0b", cyc, bus.fit_wr_en_o, v);
            end else begin
                e = q_fit.pop_front();
                if (bus.fit_addr_o !== IDX_WIDTH'(e) || bus.fit_data_o !== energy_of(e)) begin
                    errors++;
                    $display("FAIL fit_write cyc=%0d: got addr %0d data %0d, required addr %0d data %0d",
                             cyc, bus.fit_addr_o, bus.fit_data_o, e, energy_of(e));
                end
            end
        end
        if (bus.done_o) begin
            n_done++;
            done_cyc = cyc;
        end
        for (int k = 3; k > 0; k--) begin
            hv[k] = hv[k-1];
            hi[k] = hi[k-1];
        end
        hv[0]    = bus.eval_valid_o;
        hi[0]    = int'(bus.eval_idx_o);
        prev_cfg = int'(bus.cfg_addr_o);
        prev_rd  = bus.pop_rd_en_o;
        prev_pa  = int'(bus.pop_addr_o);
    endtask

    task automatic clear_history();
        for (int k = 0; k < 4; k++) begin
            hv[k] = 1'b0;
            hi[k] = 0;
        end
    endtask

    // Runs one generation; optional start pokes in ISSUE/DRAIN, optional abort by reset
    task automatic run_generation(input logic reload, input int lat, input bit exp_load,
                                  input bit pokes, input int abort_at);
        bit drain_poked;
        int tail;
        cur_lat = lat;
        q_self.delete(); q_int.delete(); q_pop.delete(); q_eval.delete(); q_fit.delete();
        n_self = 0; n_int = 0; n_pop = 0; n_ev = 0; n_fit = 0; n_done = 0;
        first_pop = -1; last_pop = -1; first_ev = -1; done_cyc = -1;
        if (exp_load) begin
            for (int k = 0; k < 3; k++)  q_self.push_back(k + 1);
            for (int k = 3; k < 12; k++) q_int.push_back(k + 1);
        end
        for (int k = 0; k < POP_SIZE; k++) begin
            q_pop.push_back(k);
            q_eval.push_back(k);
        end
        bus.start_i  = 1'b1;
        bus.reload_i = reload;
        start_cyc    = cyc;
        step();
        bus.start_i  = 1'b0;
        bus.reload_i = 1'b0;
        drain_poked  = 1'b0;
        tail         = 0;
        for (int n = 0; n < 300; n++) begin
            step();
            bus.start_i  = 1'b0;
            bus.reload_i = 1'b0;
            if (pokes) begin
                if (bus.pop_rd_en_o && int'(bus.pop_addr_o) == 10) begin
                    bus.start_i  = 1'b1;
                    bus.reload_i = 1'b1;
                end
                if (!drain_poked && n_pop == POP_SIZE && !bus.pop_rd_en_o && n_done == 0) begin
                    bus.start_i  = 1'b1;
                    bus.reload_i = 1'b1;
                    drain_poked  = 1'b1;
                end
            end
            if (abort_at >= 0 && bus.pop_rd_en_o && int'(bus.pop_addr_o) == abort_at) begin
                rst_n = 1'b0;
                bus.eval_valid_i  = 1'b0;
                bus.eval_idx_i    = '0;
                bus.eval_energy_i = '0;
                #1;
                checks++;
                if ({bus.cfg_addr_o, bus.wr_self_valid_o, bus.self_energy_o, bus.wr_interact_valid_o,
                     bus.interact_energy_o, bus.pop_rd_en_o, bus.pop_addr_o, bus.eval_valid_o,
                     bus.eval_ind_o, bus.eval_idx_o, bus.fit_wr_en_o, bus.fit_addr_o,
                     bus.fit_data_o, bus.best_idx_o, bus.busy_o, bus.done_o} !== '0) begin
                    errors++;
                    $display("FAIL abort_outputs: got busy=%0b pop_rd=%0b pop_addr=%0d eval_v=%0b, required all 0",
                             bus.busy_o, bus.pop_rd_en_o, bus.pop_addr_o, bus.eval_valid_o);
                end
                checks++;
                if (bus.best_energy_o !== EXP_BEST_E_RST) begin
                    errors++;
                    $display("FAIL abort_best_energy: got %h, required %h", bus.best_energy_o, EXP_BEST_E_RST);
                end
                clear_history();
                q_fit.delete();
                for (int k = 0; k < 3; k++) step();
                rst_n = 1'b1;
                for (int k = 0; k < 4; k++) step();
                return;
            end
            if (n_done > 0) tail++;
            if (tail == 6) break;
        end
        bus.start_i  = 1'b0;
        bus.reload_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) step();
        checks++;
        if (bus.busy_o !== 1'b0 || bus.done_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_status: got busy=%0b done=%0b, required 0/0", bus.busy_o, bus.done_o);
        end
        checks++;
        if ({bus.cfg_addr_o, bus.wr_self_valid_o, bus.wr_interact_valid_o, bus.pop_rd_en_o,
             bus.pop_addr_o, bus.eval_valid_o, bus.eval_idx_o, bus.fit_wr_en_o} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got cfg_addr=%0d pop_rd=%0b eval_v=%0b, required 0",
                     bus.cfg_addr_o, bus.pop_rd_en_o, bus.eval_valid_o);
        end
        checks++;
        if (bus.best_energy_o !== EXP_BEST_E_RST || bus.best_idx_o !== '0) begin
            errors++;
            $display("FAIL reset_best: got %h/%0d, required %h/0", bus.best_energy_o, bus.best_idx_o, EXP_BEST_E_RST);
        end
        rst_n = 1'b1;
        repeat (2) step();
    endtask

    task automatic test_first_gen();
        run_generation(1'b0, 4, 1'b1, 1'b0, -1);
        checks++;
        if (n_self != 3) begin errors++; $display("FAIL first_self_count: got %0d, required 3", n_self); end
        checks++;
        if (n_int != 9) begin errors++; $display("FAIL first_interact_count: got %0d, required 9", n_int); end
        checks++;
        if (first_ev - start_cyc != 14) begin
            errors++; $display("FAIL first_eval_latency: got %0d, required 14", first_ev - start_cyc);
        end
        checks++;
        if (n_pop != POP_SIZE || last_pop - first_pop != POP_SIZE - 1) begin
            errors++; $display("FAIL first_pop_burst: got %0d reads over %0d cycles, required 50 over 49", n_pop, last_pop - first_pop);
        end
        checks++;
        if (n_ev != POP_SIZE) begin errors++; $display("FAIL first_eval_count: got %0d, required 50", n_ev); end
        checks++;
        if (n_fit != POP_SIZE) begin errors++; $display("FAIL first_fit_count: got %0d, required 50", n_fit); end
        checks++;
        if (n_done != 1) begin errors++; $display("FAIL first_done_count: got %0d, required 1", n_done); end
        checks++;
        if (done_cyc - first_pop != 55) begin
            errors++; $display("FAIL first_done_time: got %0d, required 55", done_cyc - first_pop);
        end
        checks++;
        if (bus.best_energy_o !== EXP_BEST_E || bus.best_idx_o !== EXP_BEST_I) begin
            errors++; $display("FAIL first_best: got %0d/%0d, required %0d/%0d", bus.best_energy_o, bus.best_idx_o, EXP_BEST_E, EXP_BEST_I);
        end
        checks++;
        if (bus.busy_o !== 1'b0) begin errors++; $display("FAIL first_idle_busy: got %0b, required 0", bus.busy_o); end
    endtask

    task automatic test_idle_write_no_reload();
        bus.eval_valid_i  = 1'b1;
        bus.eval_idx_i    = 8'd7;
        bus.eval_energy_i = 10'd1;
        #1;
        checks++;
        if ({bus.fit_wr_en_o, bus.fit_addr_o, bus.fit_data_o} !== {1'b1, 8'd7, 10'd1}) begin
            errors++;
            $display("FAIL idle_fit_write: got en=%0b addr=%0d data=%0d, required 1/7/1", bus.fit_wr_en_o, bus.fit_addr_o, bus.fit_data_o);
        end
        step();
        run_generation(1'b0, 4, 1'b0, 1'b0, -1);
        checks++;
        if (n_self != 0 || n_int != 0) begin
            errors++; $display("FAIL noreload_cfg: got %0d/%0d strobes, required 0/0", n_self, n_int);
        end
        checks++;
        if (n_pop != POP_SIZE || n_ev != POP_SIZE) begin
            errors++; $display("FAIL noreload_issue: got %0d reads %0d evals, required 50/50", n_pop, n_ev);
        end
        checks++;
        if (first_pop - start_cyc != 1) begin
            errors++; $display("FAIL noreload_issue_start: got %0d, required 1", first_pop - start_cyc);
        end
        checks++;
        if (n_done != 1 || done_cyc - first_pop != 55) begin
            errors++; $display("FAIL noreload_done: got %0d pulses at %0d, required 1 at 55", n_done, done_cyc - first_pop);
        end
    endtask

    task automatic test_start_ignored();
        run_generation(1'b0, 4, 1'b0, 1'b1, -1);
        checks++;
        if (n_done != 1) begin errors++; $display("FAIL ignored_done_count: got %0d, required 1", n_done); end
        checks++;
        if (n_self != 0 || n_int != 0 || n_pop != POP_SIZE) begin
            errors++; $display("FAIL ignored_activity: got %0d/%0d/%0d, required 0/0/50", n_self, n_int, n_pop);
        end
        checks++;
        if (done_cyc - first_pop != 55) begin
            errors++; $display("FAIL ignored_done_time: got %0d, required 55", done_cyc - first_pop);
        end
    endtask

    task automatic test_mid_reset();
        run_generation(1'b0, 4, 1'b0, 1'b0, 20);
        checks++;
        if (n_done != 0) begin errors++; $display("FAIL abort_done: got %0d, required 0", n_done); end
        run_generation(1'b0, 4, 1'b1, 1'b0, -1);
        checks++;
        if (n_self != 3 || n_int != 9) begin
            errors++; $display("FAIL reload_after_abort: got %0d/%0d strobes, required 3/9", n_self, n_int);
        end
        checks++;
        if (n_done != 1 || n_fit != POP_SIZE) begin
            errors++; $display("FAIL abort_next_gen: got done=%0d fits=%0d, required 1/50", n_done, n_fit);
        end
    endtask

    task automatic test_drain_edge();
        run_generation(1'b1, 0, 1'b1, 1'b0, -1);
        checks++;
        if (n_done != 1 || done_cyc - first_pop != 51) begin
            errors++; $display("FAIL drain_edge_done: got %0d pulses at %0d, required 1 at 51", n_done, done_cyc - first_pop);
        end
        checks++;
        if (n_fit != POP_SIZE) begin errors++; $display("FAIL drain_edge_fits: got %0d, required 50", n_fit); end
        checks++;
        if (bus.best_energy_o !== EXP_BEST_E || bus.best_idx_o !== EXP_BEST_I) begin
            errors++; $display("FAIL drain_edge_best: got %0d/%0d, required %0d/%0d", bus.best_energy_o, bus.best_idx_o, EXP_BEST_E, EXP_BEST_I);
        end
    endtask

    initial begin
        bus.start_i       = 1'b0;
        bus.reload_i      = 1'b0;
        bus.cfg_data_i    = '0;
        bus.pop_data_i    = '0;
        bus.eval_valid_i  = 1'b0;
        bus.eval_energy_i = '0;
        bus.eval_idx_i    = '0;
        clear_history();
        test_reset();
        test_first_gen();
        test_idle_write_no_reload();
        test_start_ignored();
        test_mid_reset();
        test_drain_edge();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire

// File: doc/fitness_eval_ctrl.md
FITNESS_EVAL_CTRL -- requirements
Module: fitness_eval_ctrl

Interface
REQ-001 Parameters (name, default, meaning):
- NUM_PARTICLE_TYPE, 3, particle types.
- DATA_WIDTH, 4, energy coefficient width.
- INDIVIDUAL_LENGTH, 22, individual vector width.
- SELF_FIT_LENGTH, 10, total energy width.
- POP_SIZE, 50, individuals per generation.
- IDX_WIDTH, 8, index/address width.
REQ-002 Ports (name, direction, width, meaning):
- clk_i, in, 1, clock.
- rst_n, in, 1, reset; asynchronous, active-low.
- start_i, in, 1, begin one generation evaluation.
- reload_i, in, 1, sampled with start_i; 1 = reload coefficients first.
- cfg_addr_o, out, 4, coefficient ROM address.
- cfg_data_i, in, DATA_WIDTH, ROM data, valid 1 cycle after address.
- self_energy_o, out, DATA_WIDTH, evaluator self-energy write data.
- interact_energy_o, out, DATA_WIDTH, evaluator interaction write data.
- wr_self_valid_o, out, 1, self-energy write strobe.
- wr_interact_valid_o, out, 1, interaction write strobe.
- pop_rd_en_o, out, 1, population memory read.
- pop_addr_o, out, IDX_WIDTH, population address.
- pop_data_i, in, INDIVIDUAL_LENGTH, read data, 1-cycle latency.
- eval_valid_o, out, 1, evaluator in_valid.
- eval_ind_o, out, INDIVIDUAL_LENGTH, evaluator individual.
- eval_idx_o, out, IDX_WIDTH, evaluator index.
- eval_valid_i, in, 1, evaluator out_valid.
- eval_energy_i, in, SELF_FIT_LENGTH, evaluator total energy.
- eval_idx_i, in, IDX_WIDTH, evaluator write-back index.
- fit_wr_en_o, out, 1, fitness memory write.
- fit_addr_o, out, IDX_WIDTH, fitness address.
- fit_data_o, out, SELF_FIT_LENGTH, fitness data.
- best_energy_o, out, SELF_FIT_LENGTH, minimum energy this generation.
- best_idx_o, out, IDX_WIDTH, index of that minimum.
- busy_o, out, 1, high from start acceptance to done.
- done_o, out, 1, one-cycle completion pulse.

Function
REQ-003 FSM states SHALL be IDLE, LOAD_SE, LOAD_IE, ISSUE, DRAIN, DONE; one-hot or binary is implementer's choice.
REQ-004 IDLE SHALL accept start_i only; start_i in any other state SHALL be ignored.
REQ-005 Transitions from IDLE on start_i: to LOAD_SE if reload_i=1 or no load since reset; otherwise to ISSUE.
REQ-006 LOAD_SE SHALL drive cfg_addr_o 0,1,2 on consecutive cycles.
REQ-007 Each read SHALL assert wr_self_valid_o with self_energy_o=cfg_data_i exactly 1 cycle after its address; exactly 3 strobes.
REQ-008 LOAD_IE SHALL drive cfg_addr_o 3..11, row-major (row=(a-3)/3, col=(a-3)%3).
REQ-009 LOAD_IE writes SHALL be exactly 9 wr_interact_valid_o strobes, each 1 cycle after its address; self and interact strobes never in the same cycle.
REQ-010 ISSUE SHALL assert pop_rd_en_o with pop_addr_o=0..POP_SIZE-1, one per cycle, no gaps.
REQ-011 eval_valid_o, eval_ind_o=pop_data_i and eval_idx_o=address SHALL follow each read by 1 cycle; eval_valid_o is low at all other times.
REQ-012 ISSUE SHALL enter DRAIN after issuing address POP_SIZE-1.
REQ-013 Every eval_valid_i cycle, in any state, SHALL produce the same-cycle combinational write fit_wr_en_o=1, fit_addr_o=eval_idx_i, fit_data_o=eval_energy_i.
REQ-014 A receive counter SHALL count eval_valid_i pulses. DRAIN SHALL go to DONE when the count reaches POP_SIZE, including a pulse arriving in the last ISSUE cycle.
REQ-015 DONE SHALL last 1 cycle, assert done_o, clear the counters and return to IDLE; busy_o SHALL be low in IDLE only.
REQ-016 eval_valid_i received in IDLE SHALL be written (REQ-013) but not counted.
REQ-017 Counters SHALL be IDX_WIDTH bits, with no wrap before POP_SIZE.

Reset
REQ-018 Asynchronous reset SHALL force IDLE, clear all counters and the "loaded" flag, and drive every output to 0, except best_energy_o = all-ones.
REQ-019 Reset mid-generation SHALL abandon the generation without a done_o pulse; the next start_i SHALL reload coefficients.

Configuration
REQ-020 Macro FEC_BEST_TRACK_EN defined: on start acceptance, best_energy_o SHALL be set to all-ones and best_idx_o to 0.
REQ-021 With FEC_BEST_TRACK_EN, each counted result SHALL update best when eval_energy_i < best_energy_o, strictly; ties keep the earlier result.
REQ-022 With FEC_BEST_TRACK_EN, best values SHALL hold after DONE.
REQ-023 FEC_BEST_TRACK_EN undefined: best_energy_o and best_idx_o SHALL be constant 0 and no tracking logic SHALL be built.

Verification
REQ-024 Reset then start_i with reload_i=0, ROM addr a holding a+1 -> self strobes carry 1,2,3; interact strobes carry 4..12; the first eval_valid_o appears 14 cycles after start.
REQ-025 Second start_i with reload_i=0 -> no cfg strobes; pop_addr_o 0..49 contiguous; 50 eval_valid_o pulses.
REQ-026 Fixed 4-cycle evaluator model, energy=idx+100 except idx 17=5 and idx 30=5 -> 50 fitness writes; done_o once; best_energy_o=5, best_idx_o=17 (macro on), 0/0 (macro off).
REQ-027 start_i pulsed during ISSUE and DRAIN -> ignored; exactly one done_o.
REQ-028 rst_n low during ISSUE at address 20 -> all outputs 0, no done_o; next start_i performs a full reload.
REQ-029 Last eval_valid_i arrives in the same cycle the FSM enters DRAIN -> DONE the next cycle; count stays exact.
